// File: rtl/axil_regcheck_if.sv
// AXI4-Lite master-side bundle used by axil_regcheck_master.
interface axil_regcheck_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axil_regcheck_master.sv
// AXI4-Lite register checker: writes rotl(seed,i)^i to each register, reads it back, counts errors.
// Optional per-state watchdog enabled by defining AXIL_REGCHECK_TIMEOUT_EN.
module axil_regcheck_master #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_count,
    axil_regcheck_if.master       m_axi
);
    localparam int IDX_W   = 8;
    localparam int ROT_W   = $clog2(DATA_WIDTH);
    localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, NEXT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   seed_q, seed_d;
    logic [7:0]              err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    launch;
    logic [1:0]              rd_errs;
    logic                    timeout;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [DATA_WIDTH-1:0] s,
                                                      input logic [IDX_W-1:0] i);
        logic [2*DATA_WIDTH-1:0] dbl;
        dbl = {s, s} << i[ROT_W-1:0];
        return dbl[2*DATA_WIDTH-1:DATA_WIDTH] ^ DATA_WIDTH'(i);
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, n};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

`ifdef AXIL_REGCHECK_TIMEOUT_EN
    // Down-counter reloads on every state change; terminal count in a bus state is the 1023rd cycle.
    logic [9:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q) begin
            wdog_d = 10'd1022;
        end else if (wdog_q != 10'd0) begin
            wdog_d = wdog_q - 10'd1;
        end
    end

    assign timeout = (state_q inside {WRITE, WRESP, RADDR, RDATA}) && (wdog_q == 10'd0);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wdog_q <= 10'd1022;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seed_d    = seed_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        busy_d    = busy_q;
        done_d    = done_q;
        launch    = 1'b0;
        rd_errs   = 2'd0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    seed_d  = seed;
                    idx_d   = '0;
                    err_d   = 8'd0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = WRITE;
                    launch  = 1'b1;
                end
            end
            WRITE: begin
                if (m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
                if (m_axi.M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (m_axi.M_AXI_BVALID) begin
                    bready_d  = 1'b0;
                    arvalid_d = 1'b1;
                    if (m_axi.M_AXI_BRESP != 2'b00) err_d = sat_add(err_q, 2'd1);
                    state_d   = RADDR;
                end
            end
            RADDR: begin
                if (m_axi.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (m_axi.M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    rd_errs  = 2'(m_axi.M_AXI_RRESP != 2'b00) + 2'(m_axi.M_AXI_RDATA != wdata_q);
                    err_d    = sat_add(err_q, rd_errs);
                    state_d  = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = WRITE;
                    launch  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // wdata_q doubles as the read-back reference, so it is only reloaded on a new write.
        if (launch) begin
            addr_d    = BASE_ADDR + (ADDR_WIDTH'(idx_d) << BYTE_SH);
            wdata_d   = pattern(seed_d, idx_d);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end

        if (timeout) begin
            err_d     = sat_add(err_q, 2'd1);
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = DONE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            seed_q    <= '0;
            err_q     <= 8'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign pass      = done_q && (err_q == 8'd0);

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = '1;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axil_regcheck_master.sv
// Directed bench for axil_regcheck_master: memory slave with delay/fault knobs plus pattern/error model.
`timescale 1ns/1ps
module tb_axil_regcheck_master;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NREG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic        busy, done, pass;
    logic [7:0]  err_count;

    axil_regcheck_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axil_regcheck_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NREG), .BASE_ADDR(32'h0)
    ) dut (
        .ACLK(clk), .ARESET(rst), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .m_axi(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Rotate one bit at a time; plain reference for the write pattern.
    function automatic logic [31:0] model_pattern(input logic [31:0] s, input int i);
        logic [31:0] v;
        v = s;
        for (int k = 0; k < (i % 32); k++) v = {v[30:0], v[31]};
        return v ^ 32'(i);
    endfunction

    // Slave knobs and state
    int          aw_delay, w_delay, corrupt_reg;
    bit          no_bresp;
    bit          got_aw, got_w, ar_got, b_fire, r_fire;
    int          aw_cnt, w_cnt;
    logic [31:0] aw_a, w_d, ar_a;
    logic [31:0] mem [16];

    always @(posedge clk) begin
        #1;
        if (bus.M_AXI_AWREADY) begin
            got_aw = 1; bus.M_AXI_AWREADY = 0; aw_cnt = 0;
        end else if (bus.M_AXI_AWVALID && !got_aw) begin
            if (aw_cnt >= aw_delay) begin bus.M_AXI_AWREADY = 1; aw_a = bus.M_AXI_AWADDR; end
            else aw_cnt++;
        end
        if (bus.M_AXI_WREADY) begin
            got_w = 1; bus.M_AXI_WREADY = 0; w_cnt = 0;
        end else if (bus.M_AXI_WVALID && !got_w) begin
            if (w_cnt >= w_delay) begin bus.M_AXI_WREADY = 1; w_d = bus.M_AXI_WDATA; end
            else w_cnt++;
        end
        if (b_fire) bus.M_AXI_BVALID = 0;
        if (!bus.M_AXI_BVALID && got_aw && got_w && !no_bresp) begin
            mem[aw_a[5:2]] = w_d;
            bus.M_AXI_BRESP = 2'b00; bus.M_AXI_BVALID = 1;
            got_aw = 0; got_w = 0;
        end
        if (bus.M_AXI_ARREADY) begin
            bus.M_AXI_ARREADY = 0; ar_got = 1;
        end else if (bus.M_AXI_ARVALID) begin
            bus.M_AXI_ARREADY = 1; ar_a = bus.M_AXI_ARADDR;
        end
        if (r_fire) bus.M_AXI_RVALID = 0;
        if (ar_got && !bus.M_AXI_RVALID) begin
            bus.M_AXI_RDATA = mem[ar_a[5:2]]; bus.M_AXI_RRESP = 2'b00;
            if (int'(ar_a[5:2]) == corrupt_reg) begin
                bus.M_AXI_RDATA = bus.M_AXI_RDATA ^ 32'h1; bus.M_AXI_RRESP = 2'b10;
            end
            bus.M_AXI_RVALID = 1; ar_got = 0;
        end
        b_fire = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
        r_fire = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
    end

    // Model state for the compare process
    logic [31:0] run_seed;
    int          wr_n, wd_n, rd_n, b_n, exp_err, bready_cycles;
    logic [31:0] wlog [NREG];
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic        p_rst = 1'b1;
    logic [31:0] p_awa, p_wd, p_ara;

    always @(negedge clk) begin
        int e;
        if (!rst && !p_rst) begin
            if (busy) check("err_live", err_count, exp_err);
            check("pass_rule", pass, done && (err_count == 8'd0));
            check("busy_done_excl", busy && done, 0);
            if (p_awv && !p_awr) begin
                check("awvalid_hold", bus.M_AXI_AWVALID, 1);
                check("awaddr_hold", bus.M_AXI_AWADDR, p_awa);
            end
            if (p_wv && !p_wr) begin
                check("wvalid_hold", bus.M_AXI_WVALID, 1);
                check("wdata_hold", bus.M_AXI_WDATA, p_wd);
            end
            if (p_arv && !p_arr) begin
                check("arvalid_hold", bus.M_AXI_ARVALID, 1);
                check("araddr_hold", bus.M_AXI_ARADDR, p_ara);
            end
            if (bus.M_AXI_AWVALID) check("aw_one_outstanding", wr_n, rd_n);
            if (bus.M_AXI_ARVALID) check("ar_after_bresp", b_n, rd_n + 1);
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                check("awaddr", bus.M_AXI_AWADDR, 32'(wr_n * 4));
                check("awprot", bus.M_AXI_AWPROT, 0);
                wr_n++;
            end
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                check("wdata", bus.M_AXI_WDATA, model_pattern(run_seed, wd_n));
                check("wstrb", bus.M_AXI_WSTRB, 4'hF);
                if (wd_n < NREG) wlog[wd_n] = bus.M_AXI_WDATA;
                wd_n++;
            end
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                check("araddr", bus.M_AXI_ARADDR, 32'(rd_n * 4));
                check("arprot", bus.M_AXI_ARPROT, 0);
            end
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
                e = (bus.M_AXI_BRESP != 2'b00) ? 1 : 0;
                exp_err = (exp_err + e > 255) ? 255 : exp_err + e;
                b_n++;
            end
            if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
                e = ((bus.M_AXI_RRESP != 2'b00) ? 1 : 0)
                  + ((bus.M_AXI_RDATA != model_pattern(run_seed, rd_n)) ? 1 : 0);
                exp_err = (exp_err + e > 255) ? 255 : exp_err + e;
                rd_n++;
            end
            if (bus.M_AXI_BREADY) bready_cycles++;
        end
        p_awv = bus.M_AXI_AWVALID; p_awr = bus.M_AXI_AWREADY; p_awa = bus.M_AXI_AWADDR;
        p_wv  = bus.M_AXI_WVALID;  p_wr  = bus.M_AXI_WREADY;  p_wd  = bus.M_AXI_WDATA;
        p_arv = bus.M_AXI_ARVALID; p_arr = bus.M_AXI_ARREADY; p_ara = bus.M_AXI_ARADDR;
        p_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_slave();
        got_aw = 0; got_w = 0; ar_got = 0; b_fire = 0; r_fire = 0; aw_cnt = 0; w_cnt = 0;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
        bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RRESP = 0; bus.M_AXI_RDATA = 0;
        for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    endtask

    task automatic reset_model(input logic [31:0] s);
        run_seed = s; wr_n = 0; wd_n = 0; rd_n = 0; b_n = 0; exp_err = 0; bready_cycles = 0;
        for (int k = 0; k < NREG; k++) wlog[k] = 32'hX;
    endtask

    task automatic run_start(input logic [31:0] s);
        tick();
        start = 1; seed = s;
        reset_model(s);
        tick();
        start = 0; seed = ~s;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!done && n < budget) begin tick(); n++; end
        check(name, done, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_awvalid"}, bus.M_AXI_AWVALID, 0);
        check({tag, "_wvalid"}, bus.M_AXI_WVALID, 0);
        check({tag, "_bready"}, bus.M_AXI_BREADY, 0);
        check({tag, "_arvalid"}, bus.M_AXI_ARVALID, 0);
        check({tag, "_rready"}, bus.M_AXI_RREADY, 0);
    endtask

    initial begin
        int n;
        aw_delay = 0; w_delay = 0; corrupt_reg = -1; no_bresp = 0;
        clear_slave();
        reset_model(32'h0);

        // Reset state; start held together with reset must be ignored
        rst = 1;
        repeat (2) tick();
        start = 1; seed = 32'h5555_AAAA;
        tick();
        start = 0;
        check_idle_outputs("reset");
        rst = 0;
        tick();
        check("idle_no_start_busy", busy, 0);

        // Zero-wait slave, known seed, with a start pulse mid-run that must be ignored
        run_start(32'h0101_FFFF);
        repeat (6) tick();
        start = 1; seed = 32'hDEAD_BEEF;
        tick();
        start = 0;
        wait_done(500, "t1_done_reached");
        check("t1_busy", busy, 0);
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);
        check("t1_writes", wr_n, NREG);
        check("t1_reads", rd_n, NREG);
        check("t1_w0", wlog[0], 32'h0101_FFFF);
        check("t1_w1", wlog[1], 32'h0203_FFFF);
        check("t1_w2", wlog[2], 32'h0407_FFFE);
        check("t1_w3", wlog[3], 32'h080F_FFFB);
        repeat (3) tick();
        check("t1_done_hold", done, 1);

        // AWREADY three cycles after WREADY, then the reverse order
        for (int t = 0; t < 2; t++) begin
            clear_slave();
            aw_delay = (t == 0) ? 3 : 0;
            w_delay  = (t == 0) ? 0 : 3;
            run_start((t == 0) ? 32'hA5A5_0F0F : 32'h8000_0001);
            wait_done(800, "t2_done_reached");
            check("t2_pass", pass, 1);
            check("t2_err", err_count, 0);
            check("t2_aw_count", wr_n, NREG);
            check("t2_w_count", wd_n, NREG);
            check("t2_b_count", b_n, NREG);
            for (int k = 0; k < NREG; k++)
                check("t2_mem", mem[k], model_pattern(run_seed, k));
        end

        // Register 2 read-back corrupted in bit 0 with SLVERR
        clear_slave();
        aw_delay = 0; w_delay = 0; corrupt_reg = 2;
        run_start(32'h1234_5678);
        wait_done(500, "t3_done_reached");
        check("t3_err", err_count, 2);
        check("t3_pass", pass, 0);
        check("t3_model_err", exp_err, 2);
        corrupt_reg = -1;

        // Reset while AWVALID is held for register 1, then a clean run with seed 0
        clear_slave();
        aw_delay = 2;
        run_start(32'hCAFE_F00D);
        n = 0;
        while (!(bus.M_AXI_AWVALID && wr_n == 1) && n < 200) begin tick(); n++; end
        check("t4_aw_reg1_seen", bus.M_AXI_AWVALID && (wr_n == 1), 1);
        rst = 1;
        tick();
        check_idle_outputs("t4_midrst");
        rst = 0;
        clear_slave();
        reset_model(32'h0);
        aw_delay = 0;
        tick();
        run_start(32'h0);
        wait_done(500, "t4_done_reached");
        check("t4_pass", pass, 1);
        check("t4_err", err_count, 0);
        check("t4_w3", wlog[3], 32'h0000_0003);

`ifdef AXIL_REGCHECK_TIMEOUT_EN
        // Slave never answers the write: watchdog ends the run from WRESP
        clear_slave();
        no_bresp = 1;
        run_start(32'h0000_0001);
        wait_done(3000, "t5_done_reached");
        check("t5_err", err_count, 1);
        check("t5_bready", bus.M_AXI_BREADY, 0);
        check("t5_pass", pass, 0);
        check("t5_wresp_cycles", bready_cycles, 1023);
        check("t5_arvalid", bus.M_AXI_ARVALID, 0);
        no_bresp = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
